// File: rtl/lii_out_packer.sv
// lii_out_packer: joins NS kernel output streams into one word, buffers words in a
// DEPTH-entry FIFO and serialises each word onto a PW-bit LII phy channel as NB beats,
// most-significant beat first. The kernel clock enable follows real FIFO space, so the
// kernel may run ahead of phy back-pressure by up to DEPTH words.
module lii_out_packer #(
  parameter int unsigned NS     = 2,
  parameter int unsigned SW     = 16,
  parameter int unsigned PW     = 128,
  parameter int unsigned DEPTH  = 4,
  parameter logic [7:0]  SRC_ID = 8'h00,
  parameter logic [7:0]  DST_ID = 8'h01,
  localparam int unsigned TW    = NS * SW,
  localparam int unsigned NB    = (TW + PW - 1) / PW,
  localparam int unsigned CW    = $clog2(DEPTH + 1),
  localparam int unsigned BW    = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic             aclk,
  input  logic             arst,
  input  logic [NS*SW-1:0] s_tdata,
  input  logic [NS-1:0]    s_tvalid,
  output logic [NS-1:0]    s_tready,
  output logic [PW-1:0]    lii_out_tdata,
  output logic             lii_out_tvalid,
  input  logic             lii_out_tready,
  output logic             lii_out_last,
  output logic [7:0]       lii_out_src,
  output logic [7:0]       lii_out_dst,
  output logic             ce,
  output logic [CW-1:0]    fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  // Stored word width: the packed word zero-extended to a whole number of beats.
  localparam int unsigned XW = NB * PW;
  localparam logic [CW-1:0] Full     = CW'(DEPTH);
  localparam logic [BW-1:0] LastBeat = BW'(NB - 1);

  logic [XW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [BW-1:0] beat_q, beat_d;

  logic [XW-1:0] word_in;
  logic [XW-1:0] head;
  logic          push;
  logic          pop;
  logic          out_valid;
  logic          at_last;
  logic          beat_xfer;

  // Pack streams with stream 0 in the MSBs; upper bits beyond TW stay zero.
  always_comb begin
    word_in = '0;
    for (int i = 0; i < NS; i++) begin
      word_in[(NS - 1 - i) * SW +: SW] = s_tdata[i * SW +: SW];
    end
  end

  // Handshake decode. Full is taken from the registered count, so a pop in the same
  // cycle never frees a slot for a push (no bypass).
  always_comb begin
    push      = (&s_tvalid) & (count_q != Full) & ~arst;
    out_valid = (count_q != '0) & ~arst;
    at_last   = (beat_q == LastBeat);
    beat_xfer = out_valid & lii_out_tready;
    pop       = beat_xfer & at_last;
  end

  // Next-state for pointers, occupancy and beat index; reset discards any partial word.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    beat_d   = beat_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end

    if (beat_xfer) begin
      beat_d = at_last ? '0 : beat_q + BW'(1);
    end

    if (arst) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      beat_d   = '0;
    end
  end

  // Control state registers.
  always_ff @(posedge aclk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
    beat_q   <= beat_d;
  end

  // Word storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= word_in;
    end
  end

  // Select the current beat of the head word, most-significant beat at index 0.
  // Head and beat index only move on a transfer, so data holds while stalled.
  always_comb begin
    head          = mem_q[rd_ptr_q];
    lii_out_tdata = head[XW-1 -: PW];
    for (int k = 1; k < NB; k++) begin
      if (beat_q == BW'(k)) begin
        lii_out_tdata = head[(NB - k) * PW - 1 -: PW];
      end
    end
  end

  // Output drive.
  always_comb begin
    s_tready       = {NS{push}};
    ce             = push;
    lii_out_tvalid = out_valid;
    lii_out_last   = out_valid & at_last;
    lii_out_src    = SRC_ID;
    lii_out_dst    = DST_ID;
    fifo_count     = count_q;
  end

endmodule

// File: tb/tb_lii_out_packer.sv
// Bench for lii_out_packer: instance A (NS=2, SW=16, one beat per word) and instance B
// (NS=3, SW=64, two beats per word), checked against a queue-based reference model.
module tb_lii_out_packer;

  localparam int unsigned DEPTH = 4;

  logic aclk = 1'b0;
  logic arst;
  always #5 aclk = ~aclk;

  // Instance A
  logic [31:0]  a_tdata;
  logic [1:0]   a_tvalid, a_s_tready;
  logic [127:0] a_odata;
  logic         a_ovalid, a_oready, a_last, a_ce;
  logic [7:0]   a_src, a_dst;
  logic [2:0]   a_cnt;

  // Instance B
  logic [191:0] b_tdata;
  logic [2:0]   b_tvalid, b_s_tready;
  logic [127:0] b_odata;
  logic         b_ovalid, b_oready, b_last, b_ce;
  logic [7:0]   b_src, b_dst;
  logic [2:0]   b_cnt;

  lii_out_packer #(.NS(2), .SW(16), .PW(128), .DEPTH(DEPTH), .SRC_ID(8'h00), .DST_ID(8'h01))
  dut_a (
    .aclk(aclk), .arst(arst), .s_tdata(a_tdata), .s_tvalid(a_tvalid), .s_tready(a_s_tready),
    .lii_out_tdata(a_odata), .lii_out_tvalid(a_ovalid), .lii_out_tready(a_oready),
    .lii_out_last(a_last), .lii_out_src(a_src), .lii_out_dst(a_dst), .ce(a_ce),
    .fifo_count(a_cnt)
  );

  lii_out_packer #(.NS(3), .SW(64), .PW(128), .DEPTH(DEPTH), .SRC_ID(8'h5A), .DST_ID(8'hC3))
  dut_b (
    .aclk(aclk), .arst(arst), .s_tdata(b_tdata), .s_tvalid(b_tvalid), .s_tready(b_s_tready),
    .lii_out_tdata(b_odata), .lii_out_tvalid(b_ovalid), .lii_out_tready(b_oready),
    .lii_out_last(b_last), .lii_out_src(b_src), .lii_out_dst(b_dst), .ce(b_ce),
    .fifo_count(b_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queues of whole packed words plus B's beat position.
  logic [127:0] qa[$];
  logic [255:0] qb[$];
  int           beat_b = 0;

  function automatic logic [127:0] pack_a(input logic [31:0] d);
    logic [127:0] w = '0;
    for (int i = 0; i < 2; i++) w = (w << 16) | 128'(d[i*16 +: 16]);
    return w;
  endfunction

  function automatic logic [255:0] pack_b(input logic [191:0] d);
    logic [255:0] w = '0;
    for (int i = 0; i < 3; i++) w = (w << 64) | 256'(d[i*64 +: 64]);
    return w;
  endfunction

  function automatic logic [127:0] exp_b_beat();
    logic [255:0] t;
    if (qb.size() == 0) return '0;
    t = qb[0] >> ((1 - beat_b) * 128);
    return t[127:0];
  endfunction

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic tick();
    bit rst_now, acc_a, pop_a, acc_b, xfer_b;
    logic [127:0] dump_a;
    logic [255:0] dump_b;
    rst_now = arst;
    acc_a   = !rst_now && (&a_tvalid) && (qa.size() < DEPTH);
    pop_a   = !rst_now && (qa.size() != 0) && a_oready;
    acc_b   = !rst_now && (&b_tvalid) && (qb.size() < DEPTH);
    xfer_b  = !rst_now && (qb.size() != 0) && b_oready;
    @(posedge aclk);
    if (rst_now) begin
      qa.delete();
      qb.delete();
      beat_b = 0;
    end else begin
      if (pop_a) dump_a = qa.pop_front();
      if (acc_a) qa.push_back(pack_a(a_tdata));
      if (xfer_b) begin
        if (beat_b == 1) begin
          dump_b = qb.pop_front();
          beat_b = 0;
        end else begin
          beat_b = 1;
        end
      end
      if (acc_b) qb.push_back(pack_b(b_tdata));
    end
    #2;
  endtask

  task automatic test_reset();
    arst = 1'b1;
    a_tvalid = 2'b11; a_oready = 1'b1; a_tdata = $urandom;
    b_tvalid = 3'b111; b_oready = 1'b1; b_tdata = {$urandom, $urandom, $urandom, $urandom,
                                                   $urandom, $urandom};
    tick(); tick();
    #1;
    n_checks++; if (a_ce !== 1'b0) begin n_fail++; $display("FAIL reset_a_ce: got %0b want 0", a_ce); end
    n_checks++; if (a_s_tready !== 2'b00) begin n_fail++; $display("FAIL reset_a_tready: got %b want 00", a_s_tready); end
    n_checks++; if (a_ovalid !== 1'b0 || a_last !== 1'b0) begin n_fail++; $display("FAIL reset_a_out: got valid %b last %b want 0 0", a_ovalid, a_last); end
    n_checks++; if (b_ce !== 1'b0 || b_s_tready !== 3'b000) begin n_fail++; $display("FAIL reset_b_ready: got ce %b tready %b want 0 000", b_ce, b_s_tready); end
    n_checks++; if (b_ovalid !== 1'b0 || b_last !== 1'b0) begin n_fail++; $display("FAIL reset_b_out: got valid %b last %b want 0 0", b_ovalid, b_last); end
    n_checks++; if (a_cnt !== 3'd0 || b_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d %0d want 0 0", a_cnt, b_cnt); end
    n_checks++; if (a_src !== 8'h00 || a_dst !== 8'h01 || b_src !== 8'h5A || b_dst !== 8'hC3) begin
      n_fail++; $display("FAIL reset_ids: got %h %h %h %h want 00 01 5a c3", a_src, a_dst, b_src, b_dst); end
    arst = 1'b0; a_tvalid = 2'b00; b_tvalid = 3'b000;
    tick();
  endtask

  task automatic test_single_word();
    a_tdata = {16'h1234, 16'hABCD}; a_tvalid = 2'b11; a_oready = 1'b1;
    #1;
    n_checks++; if (a_ce !== 1'b1 || a_s_tready !== 2'b11) begin n_fail++; $display("FAIL single_accept: got ce %b tready %b want 1 11", a_ce, a_s_tready); end
    tick();
    a_tvalid = 2'b00;
    #1;
    n_checks++; if (a_ovalid !== 1'b1 || a_last !== 1'b1) begin n_fail++; $display("FAIL single_valid: got valid %b last %b want 1 1", a_ovalid, a_last); end
    n_checks++; if (a_odata !== 128'h0000_0000_0000_0000_0000_0000_ABCD_1234) begin n_fail++; $display("FAIL single_data: got %h want abcd1234", a_odata); end
    n_checks++; if (a_ce !== 1'b0) begin n_fail++; $display("FAIL single_ce_pulse: got %b want 0", a_ce); end
    tick();
    #1;
    n_checks++; if (a_ovalid !== 1'b0 || a_cnt !== 3'd0) begin n_fail++; $display("FAIL single_empty: got valid %b count %0d want 0 0", a_ovalid, a_cnt); end
  endtask

  task automatic test_two_beat();
    logic [63:0] sa, sb, sc;
    sa = {$urandom, $urandom}; sb = {$urandom, $urandom}; sc = {$urandom, $urandom};
    b_tdata = {sc, sb, sa}; b_tvalid = 3'b111; b_oready = 1'b0;
    tick();
    b_tvalid = 3'b000;
    #1;
    n_checks++; if (b_odata !== {64'h0, sa} || b_last !== 1'b0) begin n_fail++; $display("FAIL twobeat_beat0: got %h last %b want %h last 0", b_odata, b_last, {64'h0, sa}); end
    tick();
    #1;
    n_checks++; if (b_odata !== {64'h0, sa} || b_ovalid !== 1'b1) begin n_fail++; $display("FAIL twobeat_hold0: got %h valid %b want %h valid 1", b_odata, b_ovalid, {64'h0, sa}); end
    b_oready = 1'b1;
    tick();
    b_oready = 1'b0;
    #1;
    n_checks++; if (b_odata !== {sb, sc} || b_last !== 1'b1) begin n_fail++; $display("FAIL twobeat_beat1: got %h last %b want %h last 1", b_odata, b_last, {sb, sc}); end
    tick(); tick();
    #1;
    n_checks++; if (b_odata !== {sb, sc} || b_last !== 1'b1 || b_cnt !== 3'd1) begin n_fail++; $display("FAIL twobeat_hold1: got %h last %b count %0d want %h 1 1", b_odata, b_last, b_cnt, {sb, sc}); end
    b_oready = 1'b1;
    tick();
    #1;
    n_checks++; if (b_ovalid !== 1'b0 || b_cnt !== 3'd0) begin n_fail++; $display("FAIL twobeat_done: got valid %b count %0d want 0 0", b_ovalid, b_cnt); end
  endtask

  task automatic test_fill_drain();
    a_oready = 1'b0; a_tvalid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      a_tdata = $urandom;
      #1;
      n_checks++; if (a_ce !== (qa.size() < DEPTH)) begin n_fail++; $display("FAIL fill_ce[%0d]: got %b want %b", i, a_ce, qa.size() < DEPTH); end
      tick();
    end
    #1;
    n_checks++; if (a_cnt !== 3'd4 || qa.size() != 4) begin n_fail++; $display("FAIL fill_count: got %0d want 4", a_cnt); end
    n_checks++; if (a_ce !== 1'b0 || a_s_tready !== 2'b00) begin n_fail++; $display("FAIL fill_stall: got ce %b tready %b want 0 00", a_ce, a_s_tready); end
    a_oready = 1'b1;
    #1;
    n_checks++; if (a_ce !== 1'b0) begin n_fail++; $display("FAIL fill_no_bypass: got ce %b want 0", a_ce); end
    tick();
    #1;
    n_checks++; if (a_ce !== 1'b1 || a_cnt !== 3'd3) begin n_fail++; $display("FAIL fill_resume: got ce %b count %0d want 1 3", a_ce, a_cnt); end
    a_tvalid = 2'b00;
    for (int i = 0; i < 8 && qa.size() != 0; i++) begin
      #1;
      n_checks++; if (a_ovalid !== 1'b1 || a_odata !== qa[0]) begin n_fail++; $display("FAIL drain_data[%0d]: got %h valid %b want %h", i, a_odata, a_ovalid, qa[0]); end
      tick();
    end
    #1;
    n_checks++; if (a_ovalid !== 1'b0 || a_cnt !== 3'd0) begin n_fail++; $display("FAIL drain_empty: got valid %b count %0d want 0 0", a_ovalid, a_cnt); end
  endtask

  task automatic test_partial_valid();
    a_oready = 1'b1; a_tvalid = 2'b10; a_tdata = $urandom;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (a_ce !== 1'b0 || a_s_tready !== 2'b00 || a_cnt !== 3'd0) begin
        n_fail++; $display("FAIL partial_wait[%0d]: got ce %b tready %b count %0d want 0 00 0", i, a_ce, a_s_tready, a_cnt); end
      tick();
    end
    a_tvalid = 2'b11;
    #1;
    n_checks++; if (a_ce !== 1'b1 || a_s_tready !== 2'b11) begin n_fail++; $display("FAIL partial_accept: got ce %b tready %b want 1 11", a_ce, a_s_tready); end
    tick();
    a_tvalid = 2'b00;
    tick();
  endtask

  task automatic test_back_to_back();
    a_oready = 1'b0; a_tvalid = 2'b11;
    a_tdata = $urandom; tick();
    a_tdata = $urandom; tick();
    a_oready = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      a_tdata = $urandom;
      #1;
      n_checks++; if (a_cnt !== 3'd2 || a_ce !== 1'b1) begin n_fail++; $display("FAIL steady_count[%0d]: got count %0d ce %b want 2 1", i, a_cnt, a_ce); end
      n_checks++; if (a_odata !== qa[0]) begin n_fail++; $display("FAIL steady_data[%0d]: got %h want %h", i, a_odata, qa[0]); end
      tick();
    end
    a_tvalid = 2'b00;
    tick(); tick(); tick();
  endtask

  task automatic test_reset_mid_word();
    logic [63:0] sa;
    b_oready = 1'b1; b_tvalid = 3'b111;
    b_tdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    tick();
    b_tvalid = 3'b000;
    tick();
    #1;
    n_checks++; if (b_last !== 1'b1 || b_ovalid !== 1'b1) begin n_fail++; $display("FAIL midrst_at_beat1: got last %b valid %b want 1 1", b_last, b_ovalid); end
    b_oready = 1'b0; arst = 1'b1;
    #1;
    n_checks++; if (b_ovalid !== 1'b0 || b_last !== 1'b0) begin n_fail++; $display("FAIL midrst_forced: got valid %b last %b want 0 0", b_ovalid, b_last); end
    tick();
    arst = 1'b0;
    #1;
    n_checks++; if (b_ovalid !== 1'b0 || b_cnt !== 3'd0) begin n_fail++; $display("FAIL midrst_cleared: got valid %b count %0d want 0 0", b_ovalid, b_cnt); end
    sa = {$urandom, $urandom};
    b_tdata = {$urandom, $urandom, $urandom, $urandom, sa}; b_tvalid = 3'b111;
    tick();
    b_tvalid = 3'b000;
    #1;
    n_checks++; if (b_odata !== {64'h0, sa} || b_last !== 1'b0) begin n_fail++; $display("FAIL midrst_newbeat0: got %h last %b want %h last 0", b_odata, b_last, {64'h0, sa}); end
    b_oready = 1'b1;
    tick(); tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      a_tdata  = $urandom;
      a_tvalid = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      a_oready = ($urandom_range(0, 9) < 6);
      b_tdata  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      b_tvalid = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
      b_oready = ($urandom_range(0, 9) < 7);
      #1;
      n_checks++; if (a_ovalid !== (qa.size() != 0) || a_cnt !== 3'(qa.size()) || a_ce !== ((&a_tvalid) && qa.size() < DEPTH)) begin
        n_fail++; $display("FAIL rand_a_ctrl[%0d]: got valid %b count %0d ce %b want model size %0d", i, a_ovalid, a_cnt, a_ce, qa.size()); end
      if (qa.size() != 0) begin
        n_checks++; if (a_odata !== qa[0] || a_last !== 1'b1) begin n_fail++; $display("FAIL rand_a_data[%0d]: got %h last %b want %h", i, a_odata, a_last, qa[0]); end
      end
      n_checks++; if (b_ovalid !== (qb.size() != 0) || b_cnt !== 3'(qb.size()) || b_ce !== ((&b_tvalid) && qb.size() < DEPTH)) begin
        n_fail++; $display("FAIL rand_b_ctrl[%0d]: got valid %b count %0d ce %b want model size %0d", i, b_ovalid, b_cnt, b_ce, qb.size()); end
      if (qb.size() != 0) begin
        n_checks++; if (b_odata !== exp_b_beat() || b_last !== (beat_b == 1)) begin
          n_fail++; $display("FAIL rand_b_data[%0d]: got %h last %b want %h last %b", i, b_odata, b_last, exp_b_beat(), beat_b == 1); end
      end
      tick();
    end
  endtask

  initial begin
    arst = 1'b1;
    a_tdata = '0; a_tvalid = '0; a_oready = 1'b0;
    b_tdata = '0; b_tvalid = '0; b_oready = 1'b0;
    #2;
    test_reset();
    test_single_word();
    test_two_beat();
    test_fill_drain();
    test_partial_valid();
    test_back_to_back();
    test_reset_mid_word();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lii_out_packer.md
Name: lii_out_packer

Overview:
- Parametrised successor of the per-kernel LII output pack stage.
- Joins NS logic output streams from an HLS kernel into one word. Buffers words in a DEPTH-entry FIFO and serialises each word onto one PW-bit LII phy output channel as NB beats.
- Generates the kernel clock enable from the real FIFO space, not from downstream ready. The kernel can therefore run ahead of phy back-pressure by up to DEPTH words.

Parameters:
- NS, 2, number of logic input streams (>=1)
- SW, 16, width of each logic stream in bits
- PW, 128, phy packing width
- DEPTH, 4, FIFO depth in words (power of 2, >=2)
- SRC_ID, 8'h00, constant driven on lii_out_src
- DST_ID, 8'h01, constant driven on lii_out_dst
- Derived: TW = NS*SW; NB = ceil(TW/PW); CW = clog2(DEPTH+1); BW = max(1, clog2(NB))

Ports:
- aclk, in, 1, single clock for all logic
- arst, in, 1, synchronous reset, active-high
- s_tdata, in, NS*SW, flattened stream data; stream i occupies [i*SW +: SW]
- s_tvalid, in, NS, per-stream valid
- s_tready, out, NS, per-stream ready
- lii_out_tdata, out, PW, phy beat data
- lii_out_tvalid, out, 1, beat valid
- lii_out_tready, in, 1, beat ready from phy
- lii_out_last, out, 1, high on the final beat of a word
- lii_out_src, out, 8, SRC_ID
- lii_out_dst, out, 8, DST_ID
- ce, out, 1, kernel clock enable
- fifo_count, out, CW, words currently held

Behaviour:
- Clock and reset:
  - One clock, aclk. Reset arst is synchronous and active-high.
  - While arst is sampled high: FIFO pointers, fifo_count and beat index are cleared to 0.
  - While arst is high, s_tready, ce, lii_out_tvalid and lii_out_last are forced 0. src/dst stay constant.
- Word packing:
  - W = {stream0, stream1, ..., stream(NS-1)}; stream0 takes the MSBs.
  - W is zero-extended on the left to NB*PW bits.
  - Beat k (k = 0..NB-1) = bits [(NB-k)*PW-1 -: PW]. The most-significant beat is sent first.
  - When NB == 1 and TW < PW, data sits in the LSBs and the upper bits are zero.
- Accept (push):
  - accept = &s_tvalid & (fifo_count != DEPTH) & !arst.
  - All s_tready[i] = accept and ce = accept. Both are combinational; ready may depend on valid.
  - There is no partial consumption: a stream whose valid is high waits until all streams are valid.
- Output (pop):
  - lii_out_tvalid = (fifo_count != 0).
  - lii_out_tdata = beat[beat_idx] of the head word. It must be stable while tvalid & !tready.
  - lii_out_last = tvalid & (beat_idx == NB-1).
  - On tvalid & tready: if beat_idx == NB-1, pop the word and set beat_idx to 0; otherwise increment beat_idx.
- Latency: a word accepted at edge t is visible on the output in the cycle after t, i.e. 1-cycle latency when the FIFO was empty.
- Simultaneous push and pop:
  - fifo_count is unchanged; both pointers advance.
  - When the FIFO is full, push is refused in that cycle even if a pop occurs. There is no bypass; the full condition is registered.
- Pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH and never over- or underflows.
- Reset mid-word: the partially sent word is discarded. The next word after reset starts at beat 0.

Test Plan:
1. NS=2, SW=16, PW=128; streams 0xABCD and 0x1234 valid; tready=1 -> one beat next cycle, tdata=128'h...0000ABCD1234, last=1, ce pulses 1 cycle.
2. NS=3, SW=64, PW=128 (NB=2); word {A,B,C} -> beat0={64'h0,A}, beat1={B,C}; last only on beat1; beat1 held stable while tready is low.
3. tready=0, inputs always valid, DEPTH=4 -> exactly 4 accepts, fifo_count=4, then ce=0 and s_tready=0. Raise tready -> words drain in order and ce resumes the cycle after the first pop.
4. Stream1 valid, stream0 invalid for 5 cycles -> no accept, ce=0, s_tready=0. Stream0 asserts -> accept that cycle.
5. Steady state: push and pop every cycle at count=2 -> count stays 2. Run 3*DEPTH words; data order is correct across pointer wrap.
6. Assert arst during beat1 of a 2-beat word -> next cycle tvalid=0, count=0. After release, a new word starts with beat0.
